// File: rtl/hex_key_entry.sv
// hex_key_entry: turns PS/2 set-2 scan-code bytes into a hex operand.
// Break (F0) and extended (E0) prefixes are filtered by a small prefix FSM;
// make codes edit a nibble-shift accumulator that is committed on Enter.
module hex_key_entry #(
  parameter int   DATA_W    = 32,
  parameter bit   SIGNED_EN = 1'b0,
  parameter bit   OVF_MODE  = 1'b0,
  localparam int  CNT_W     = $clog2(DATA_W/4+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        key_code,
  input  logic              key_valid,
  output logic [DATA_W-1:0] value,
  output logic              value_valid,
  output logic [DATA_W-1:0] entry,
  output logic [CNT_W-1:0]  digit_count,
  output logic              negative,
  output logic              overflow
);

  localparam logic [CNT_W-1:0]  MAX_DIG = CNT_W'(DATA_W/4);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [DATA_W-1:0] VAL_ONE = DATA_W'(1);

  typedef enum logic [1:0] {
    ST_NORM    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   value_q, value_d;
  logic                value_valid_q, value_valid_d;
  logic [DATA_W-1:0]   entry_q, entry_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                negative_q, negative_d;
  logic                overflow_q, overflow_d;

  logic                is_hex;
  logic [3:0]          nibble;
  logic [DATA_W-1:0]   shifted;

  // Map a make code onto its hex nibble, flagging whether it is a digit key.
  always_comb begin
    is_hex = 1'b1;
    nibble = 4'h0;
    case (key_code)
      8'h45: nibble = 4'h0;
      8'h16: nibble = 4'h1;
      8'h1E: nibble = 4'h2;
      8'h26: nibble = 4'h3;
      8'h25: nibble = 4'h4;
      8'h2E: nibble = 4'h5;
      8'h36: nibble = 4'h6;
      8'h3D: nibble = 4'h7;
      8'h3E: nibble = 4'h8;
      8'h46: nibble = 4'h9;
      8'h1C: nibble = 4'hA;
      8'h32: nibble = 4'hB;
      8'h21: nibble = 4'hC;
      8'h23: nibble = 4'hD;
      8'h24: nibble = 4'hE;
      8'h2B: nibble = 4'hF;
      default: is_hex = 1'b0;
    endcase
  end

  assign shifted = {entry_q[DATA_W-5:0], nibble};

  // Prefix FSM and accumulator editing; pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    entry_d       = entry_q;
    count_d       = count_q;
    negative_d    = negative_q;
    overflow_d    = 1'b0;

    if (key_valid) begin
      case (state_q)
        ST_BRK, ST_EXT_BRK: state_d = ST_NORM;
        ST_EXT: begin
          if (key_code == 8'hF0) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d = ST_NORM;
            if (key_code == 8'h5A) begin
              value_d       = negative_q ? (~entry_q + VAL_ONE) : entry_q;
              value_valid_d = 1'b1;
              entry_d       = '0;
              count_d       = '0;
              negative_d    = 1'b0;
            end
          end
        end
        default: begin
          if (key_code == 8'hF0) begin
            state_d = ST_BRK;
          end else if (key_code == 8'hE0) begin
            state_d = ST_EXT;
          end else if (is_hex) begin
            if (count_q < MAX_DIG) begin
              entry_d = shifted;
              count_d = count_q + CNT_ONE;
            end else begin
              overflow_d = 1'b1;
              if (OVF_MODE) entry_d = shifted;
            end
          end else begin
            case (key_code)
              8'h66: begin
                if (count_q != '0) begin
                  entry_d = entry_q >> 4;
                  count_d = count_q - CNT_ONE;
                end
              end
              8'h76: begin
                entry_d    = '0;
                count_d    = '0;
                negative_d = 1'b0;
              end
              8'h4E: begin
                if (SIGNED_EN) negative_d = ~negative_q;
              end
              8'h5A: begin
                value_d       = negative_q ? (~entry_q + VAL_ONE) : entry_q;
                value_valid_d = 1'b1;
                entry_d       = '0;
                count_d       = '0;
                negative_d    = 1'b0;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // State registers; reset has priority over any byte in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_NORM;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      entry_q       <= '0;
      count_q       <= '0;
      negative_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      entry_q       <= entry_d;
      count_q       <= count_d;
      negative_q    <= negative_d;
      overflow_q    <= overflow_d;
    end
  end

  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign entry       = entry_q;
  assign digit_count = count_q;
  assign negative    = negative_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_hex_key_entry.sv
// Bench for hex_key_entry: two instances (default config, and signed with
// shift-on-overflow) share one byte stream; a behavioural model predicts
// each cycle's outputs into a scoreboard queue that is checked after the edge.
module tb_hex_key_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  key_code;
  logic        key_valid;

  logic [31:0] a_value, a_entry, b_value, b_entry;
  logic        a_vv, a_neg, a_ovf, b_vv, b_neg, b_ovf;
  logic [3:0]  a_cnt, b_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hex_key_entry #(.DATA_W(32), .SIGNED_EN(1'b0), .OVF_MODE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .value(a_value), .value_valid(a_vv), .entry(a_entry),
    .digit_count(a_cnt), .negative(a_neg), .overflow(a_ovf)
  );

  hex_key_entry #(.DATA_W(32), .SIGNED_EN(1'b1), .OVF_MODE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .value(b_value), .value_valid(b_vv), .entry(b_entry),
    .digit_count(b_cnt), .negative(b_neg), .overflow(b_ovf)
  );

  typedef struct {
    logic [31:0] value;
    logic        vv;
    logic [31:0] entry;
    int          cnt;
    logic        neg;
    logic        ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Model state, index 0 = dut_a, 1 = dut_b.
  int          m_st[2];
  logic [31:0] m_entry[2];
  logic [31:0] m_value[2];
  int          m_cnt[2];
  logic        m_neg[2];
  logic        m_vv[2];
  logic        m_ovf[2];
  bit          cfg_sgn[2];
  bit          cfg_ovf[2];
  logic [7:0]  hex_tab[16];
  logic [7:0]  seq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nib_of(input logic [7:0] c);
    for (int i = 0; i < 16; i++) if (hex_tab[i] == c) return i;
    return -1;
  endfunction

  task automatic m_commit(input int k);
    m_value[k] = m_neg[k] ? (32'd0 - m_entry[k]) : m_entry[k];
    m_vv[k]    = 1'b1;
    m_entry[k] = 32'd0;
    m_cnt[k]   = 0;
    m_neg[k]   = 1'b0;
  endtask

  task automatic m_step(input int k, input logic [7:0] c, input logic v, input logic r);
    int n;
    m_vv[k]  = 1'b0;
    m_ovf[k] = 1'b0;
    if (r) begin
      m_st[k] = 0; m_entry[k] = 0; m_value[k] = 0; m_cnt[k] = 0; m_neg[k] = 0;
    end else if (v) begin
      if (m_st[k] == 1 || m_st[k] == 3) m_st[k] = 0;
      else if (m_st[k] == 2) begin
        if (c == 8'hF0) m_st[k] = 3;
        else begin
          if (c == 8'h5A) m_commit(k);
          m_st[k] = 0;
        end
      end else if (c == 8'hF0) m_st[k] = 1;
      else if (c == 8'hE0) m_st[k] = 2;
      else begin
        n = nib_of(c);
        if (n >= 0) begin
          if (m_cnt[k] < 8) begin
            m_entry[k] = (m_entry[k] << 4) | 32'(n);
            m_cnt[k]++;
          end else begin
            m_ovf[k] = 1'b1;
            if (cfg_ovf[k]) m_entry[k] = (m_entry[k] << 4) | 32'(n);
          end
        end else if (c == 8'h66) begin
          if (m_cnt[k] > 0) begin m_entry[k] = m_entry[k] >> 4; m_cnt[k]--; end
        end else if (c == 8'h76) begin
          m_entry[k] = 0; m_cnt[k] = 0; m_neg[k] = 0;
        end else if (c == 8'h4E) begin
          if (cfg_sgn[k]) m_neg[k] = ~m_neg[k];
        end else if (c == 8'h5A) m_commit(k);
      end
    end
  endtask

  function automatic exp_t m_snap(input int k);
    exp_t e;
    e.value = m_value[k]; e.vv = m_vv[k]; e.entry = m_entry[k];
    e.cnt = m_cnt[k]; e.neg = m_neg[k]; e.ovf = m_ovf[k];
    return e;
  endfunction

  // One cycle: drive, predict, then check the registered response.
  task automatic send(input logic [7:0] c, input logic v, input logic r);
    exp_t ea, eb;
    @(negedge clk);
    key_code = c; key_valid = v; rst = r;
    for (int k = 0; k < 2; k++) m_step(k, c, v, r);
    q_a.push_back(m_snap(0));
    q_b.push_back(m_snap(1));
    @(posedge clk);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    $display("key=%02h v=%0b r=%0b | a: entry=%08h cnt=%0d value=%08h vv=%0b ovf=%0b | b: entry=%08h cnt=%0d value=%08h vv=%0b neg=%0b ovf=%0b",
             c, v, r, a_entry, a_cnt, a_value, a_vv, a_ovf, b_entry, b_cnt, b_value, b_vv, b_neg, b_ovf);
    check("a_value", 64'(a_value), 64'(ea.value));
    check("a_vv",    64'(a_vv),    64'(ea.vv));
    check("a_entry", 64'(a_entry), 64'(ea.entry));
    check("a_cnt",   64'(a_cnt),   64'(ea.cnt));
    check("a_neg",   64'(a_neg),   64'(ea.neg));
    check("a_ovf",   64'(a_ovf),   64'(ea.ovf));
    check("b_value", 64'(b_value), 64'(eb.value));
    check("b_vv",    64'(b_vv),    64'(eb.vv));
    check("b_entry", 64'(b_entry), 64'(eb.entry));
    check("b_cnt",   64'(b_cnt),   64'(eb.cnt));
    check("b_neg",   64'(b_neg),   64'(eb.neg));
    check("b_ovf",   64'(b_ovf),   64'(eb.ovf));
    check("a_vv_ovf_excl", 64'(a_vv & a_ovf), 64'(0));
    check("b_vv_ovf_excl", 64'(b_vv & b_ovf), 64'(0));
  endtask

  task automatic run_seq();
    foreach (seq[i]) send(seq[i], 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    hex_tab = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    cfg_sgn = '{1'b0, 1'b1};
    cfg_ovf = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_entry[k] = 0; m_value[k] = 0; m_cnt[k] = 0;
      m_neg[k] = 0; m_vv[k] = 0; m_ovf[k] = 0;
    end
    rst = 1'b1; key_valid = 1'b0; key_code = 8'h00;

    // Reset state.
    send(8'h00, 1'b0, 1'b1);
    send(8'h00, 1'b0, 1'b1);
    send(8'h00, 1'b0, 1'b0);

    // Digits with break codes in between, then Enter.
    send(8'h1E, 1'b1, 1'b0);
    check("tp1_entry_2", 64'(a_entry), 64'h2);
    seq = '{8'hF0, 8'h1E, 8'h1C};
    run_seq();
    check("tp1_entry_2A", 64'(a_entry), 64'h2A);
    seq = '{8'hF0, 8'h1C, 8'h5A};
    run_seq();
    check("tp1_value", 64'(a_value), 64'h2A);
    check("tp1_cnt", 64'(a_cnt), 64'h0);

    // Nine digits: drop vs shift on overflow.
    seq = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    run_seq();
    check("tp2_a_ovf", 64'(a_ovf), 64'h1);
    send(8'h5A, 1'b1, 1'b0);
    check("tp2_a_value", 64'(a_value), 64'h12345678);
    check("tp2_b_value", 64'(b_value), 64'h23456789);

    // Backspace.
    seq = '{8'h3E, 8'h46, 8'h66};
    run_seq();
    check("tp3_bs_entry", 64'(a_entry), 64'h8);
    seq = '{8'h2E, 8'h5A, 8'h66};
    run_seq();
    check("tp3_value", 64'(a_value), 64'h85);
    check("tp3_bs0_entry", 64'(a_entry), 64'h0);
    check("tp3_bs0_cnt", 64'(a_cnt), 64'h0);

    // Sign entry.
    seq = '{8'h4E, 8'h16};
    run_seq();
    check("tp4_b_neg", 64'(b_neg), 64'h1);
    check("tp4_a_neg", 64'(a_neg), 64'h0);
    send(8'h5A, 1'b1, 1'b0);
    check("tp4_b_value", 64'(b_value), 64'hFFFFFFFF);
    check("tp4_b_neg_clr", 64'(b_neg), 64'h0);
    check("tp4_a_value", 64'(a_value), 64'h1);

    // Keypad enter, extended break, Esc.
    seq = '{8'h1C, 8'h32, 8'hE0, 8'h5A};
    run_seq();
    check("tp5_kp_enter", 64'(a_value), 64'hAB);
    seq = '{8'h1C, 8'h32, 8'hE0, 8'hF0, 8'h5A};
    run_seq();
    check("tp5_no_commit_entry", 64'(a_entry), 64'hAB);
    send(8'h76, 1'b1, 1'b0);
    check("tp5_esc_entry", 64'(a_entry), 64'h0);
    check("tp5_esc_vv", 64'(a_vv), 64'h0);

    // Reset mid-sequence with a byte present.
    send(8'h16, 1'b1, 1'b0);
    send(8'hF0, 1'b1, 1'b0);
    send(8'h16, 1'b1, 1'b1);
    check("tp6_rst_entry", 64'(a_entry), 64'h0);
    check("tp6_rst_value", 64'(a_value), 64'h0);
    send(8'h16, 1'b1, 1'b0);
    check("tp6_after_rst", 64'(a_entry), 64'h1);

    // Random tail against the model, valid not always high.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] c;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5)       c = hex_tab[$urandom_range(0, 15)];
      else if (sel == 5) c = 8'hF0;
      else if (sel == 6) c = 8'hE0;
      else if (sel == 7) c = 8'h5A;
      else if (sel == 8) c = 8'h4E;
      else               c = ($urandom_range(0, 1) == 1) ? 8'h66 : 8'h76;
      send(c, ($urandom_range(0, 3) != 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
